seg_scan_ctrl: RTL and testbench

- Time-multiplexes a 32-bit, four-digit segment word onto the board's four common anodes and shared eight-bit cathode bus.
- The word comes from the opcode/segment decoders, 8 bits per digit, active-low, bits [31:24] = leftmost digit.
- A one-deep, handshaked pending buffer is promoted only at frame boundaries so a new word never tears mid-frame.
- Adds anti-ghosting guard time, a blank control and a blink control; sits between the decoders and the top-level anode/cathode pins.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_slot_timer.sv | 43 ++++
 rtl/seg_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants and types for the segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [7:0]            SEG_BLANK = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'b1111;

  typedef enum logic [0:0] {
    S_GUARD = 1'b0,
    S_DRIVE = 1'b1
  } state_e;

  typedef logic [IDX_W-1:0] idx_t;

endpackage
`default_nettype wire

// File: rtl/seg_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : seg_slot_timer
// Description : Free-running digit-slot counter with guard/slot/frame strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_slot_timer #(
  parameter int TICK_DIV = 100000,
  parameter int GUARD    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic last_digit_i,
  output logic slot_end_o,
  output logic guard_end_o,
  output logic frame_end_o
);

  localparam int                CNT_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  c_LAST       = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  c_GUARD_LAST = CNT_W'(GUARD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign slot_end_o  = (cnt_q == c_LAST);
  assign guard_end_o = (cnt_q == c_GUARD_LAST);
  assign frame_end_o = slot_end_o && last_digit_i;

  always_comb begin
    cnt_d = slot_end_o ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Four-digit segment scanner with guard time, blank, blink and a
//               frame-aligned one-deep pending word buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS*8-1:0] seg_in,
  input  logic                    seg_valid,
  output logic                    seg_ready,
  input  logic                    blank,
  input  logic                    blink_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_tick
);

  localparam int               WORD_W     = NUM_DIGITS * 8;
  localparam int               FC_W       = $clog2(BLINK_FRAMES + 1);
  localparam logic [FC_W-1:0]  c_FC_LAST  = FC_W'(BLINK_FRAMES - 1);
  localparam idx_t             c_IDX_LAST = idx_t'(NUM_DIGITS - 1);

  logic                  slot_end;
  logic                  guard_end;
  logic                  frame_end;
  logic                  xfer;

  state_e                state_q, state_d;
  idx_t                  idx_q, idx_d;
  logic [WORD_W-1:0]     active_q, active_d;
  logic [WORD_W-1:0]     pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;
  logic                  phase_q, phase_d;
  logic [FC_W-1:0]       fcnt_q, fcnt_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  frame_tick_q;

  seg_slot_timer #(
    .TICK_DIV (TICK_DIV),
    .GUARD    (GUARD)
  ) u_slot_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .last_digit_i (idx_q == c_IDX_LAST),
    .slot_end_o   (slot_end),
    .guard_end_o  (guard_end),
    .frame_end_o  (frame_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_GUARD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_GUARD: if (guard_end) state_d = S_DRIVE;
      S_DRIVE: if (slot_end)  state_d = S_GUARD;
      default: state_d = S_GUARD;
    endcase
  end

  // Outputs are decoded from next-state values so the registered pins line up
  // with the state register in the same cycle.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if ((state_d == S_DRIVE) && phase_d && !blank) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_d = active_q[{idx_d, 3'b000} +: 8];
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + idx_t'(1);
    end
  end

  assign seg_ready = !pend_full_q;
  assign xfer      = seg_valid && !pend_full_q;

  // Words only reach the display at a frame boundary, either from the pending
  // buffer or straight from the input when the handshake lands on that cycle.
  always_comb begin
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (frame_end && pend_full_q) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end else if (frame_end && xfer) begin
      active_d = seg_in;
    end else if (xfer) begin
      pend_d      = seg_in;
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    phase_d = phase_q;
    fcnt_d  = fcnt_q;
    if (!blink_en) begin
      phase_d = 1'b1;
      fcnt_d  = '0;
    end else if (frame_end) begin
      if (fcnt_q == c_FC_LAST) begin
        fcnt_d  = '0;
        phase_d = !phase_q;
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      active_q     <= '1;
      pend_q       <= '1;
      pend_full_q  <= 1'b0;
      phase_q      <= 1'b1;
      fcnt_q       <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      frame_tick_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      phase_q      <= phase_d;
      fcnt_q       <= fcnt_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_end;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Directed self-checking bench for seg_scan_ctrl with a word
//               scoreboard and a per-cycle frame/slot reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int TD    = 8;
  localparam int GD    = 2;
  localparam int BF    = 2;
  localparam int ND    = 4;
  localparam int FRAME = ND * TD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] seg_in;
  logic        seg_valid;
  logic        seg_ready;
  logic        blank;
  logic        blink_en;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  typedef struct {
    int          start;
    logic [31:0] w;
  } offer_t;

  offer_t      prod_q[$];
  logic [31:0] exp_q[$];

  int          n_cmp = 0;
  int          n_err = 0;
  int          g     = 0;
  int          blink_frame = 0;
  logic [31:0] cur_word;
  logic        ready_e;
  logic        blank_prev;
  logic        blink_prev;

  seg_scan_ctrl #(
    .TICK_DIV     (TD),
    .GUARD        (GD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .blank      (blank),
    .blink_en   (blink_en),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s g=%0d observed=%h expected=%h", tag, g, obs, exp);
    end
  endtask

  task automatic offer(input int start, input logic [31:0] w);
    offer_t o;
    o.start = start;
    o.w     = w;
    prod_q.push_back(o);
  endtask

  // One cycle: compare at the sample point, drive the producer, advance.
  task automatic cycle();
    int         pos, dig, sub;
    logic       lit, rdy, dark_phase;
    logic [3:0] an_e;
    logic [7:0] seg_e;
    pos = g % FRAME;
    dig = pos / TD;
    sub = pos % TD;
    if (pos == 0 && g > 0) begin
      ready_e = 1'b1;
      if (exp_q.size() > 0) cur_word = exp_q.pop_front();
    end
    dark_phase = (((g / FRAME - blink_frame) / BF) % 2) == 1;
    lit   = !blank_prev && !(blink_prev && dark_phase);
    an_e  = 4'hF;
    seg_e = 8'hFF;
    if (lit && sub >= GD) begin
      an_e[dig] = 1'b0;
      seg_e     = cur_word[dig*8 +: 8];
    end
    chk("an", 32'(an), 32'(an_e));
    chk("seg", 32'(seg), 32'(seg_e));
    chk("seg_ready", 32'(seg_ready), 32'(ready_e));
    chk("frame_tick", 32'(frame_tick), 32'(pos == 0 && g > 0));
    if (prod_q.size() > 0 && g >= prod_q[0].start) begin
      seg_valid = 1'b1;
      seg_in    = prod_q[0].w;
    end else begin
      seg_valid = 1'b0;
      seg_in    = $urandom;
    end
    rdy = seg_ready;
    @(posedge clk);
    #1;
    if (seg_valid && rdy) begin
      exp_q.push_back(seg_in);
      void'(prod_q.pop_front());
      if (pos != FRAME - 1) ready_e = 1'b0;
    end
    blank_prev = blank;
    blink_prev = blink_en;
    g++;
  endtask

  task automatic run_to(input int n);
    while (g < n) cycle();
  endtask

  task automatic restart_model();
    g          = 0;
    cur_word   = 32'hFFFF_FFFF;
    ready_e    = 1'b1;
    blank_prev = 1'b0;
    blink_prev = 1'b0;
    exp_q.delete();
    prod_q.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    seg_in    = '0;
    seg_valid = 1'b0;
    blank     = 1'b0;
    blink_en  = 1'b0;
    restart_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'h0000_000F);
    chk("rst_seg", 32'(seg), 32'h0000_00FF);
    chk("rst_ready", 32'(seg_ready), 32'd1);
    chk("rst_ftick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;

    offer(5,   32'hFF11_D585);
    offer(74,  32'hA1B2_C3D4);
    offer(80,  32'h1234_5678);
    offer(191, 32'h0F1E_2D3C);
    run_to(224);

    blink_en    = 1'b1;
    blink_frame = 7;
    run_to(362);
    blank = 1'b1;
    run_to(370);
    blank = 1'b0;
    run_to(420);
    blink_en = 1'b0;

    offer(430, 32'h8899_AABB);
    offer(460, 32'h0000_0000);
    run_to(468);
    chk("pre_rst_an", 32'(an), 32'h0000_000B);
    chk("pre_rst_seg", 32'(seg), 32'h0000_0099);
    chk("pre_rst_ready", 32'(seg_ready), 32'd0);

    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", 32'(an), 32'h0000_000F);
    chk("async_rst_seg", 32'(seg), 32'h0000_00FF);
    chk("async_rst_ready", 32'(seg_ready), 32'd1);
    chk("async_rst_ftick", 32'(frame_tick), 32'd0);
    seg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    restart_model();
    offer(3, 32'hC0FF_EE11);
    run_to(70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
